// File: rtl/ecc_err_pkg.sv
// Shared error-type encoding and capture priority for the ECC read-side error monitor.
package ecc_err_pkg;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SBIT  = 2'd1;
   localparam logic [1:0] ERR_DBIT  = 2'd2;
   localparam logic [1:0] ERR_FAULT = 2'd3;

   // Most severe flag wins: decoder fault, then double-bit, then single-bit.
   function automatic logic [1:0] err_prio(input logic sbit, input logic dbit, input logic fault);
      logic [1:0] t;
      t = ERR_NONE;
      if (fault)
         t = ERR_FAULT;
      else if (dbit)
         t = ERR_DBIT;
      else if (sbit)
         t = ERR_SBIT;
      return t;
   endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter; a clear in the same cycle as an increment yields a count of one.
module ecc_sat_cnt #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [CNT_WIDTH-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr)
         cnt_next = '0;
      if (inc && (cnt_next != CNT_MAX))
         cnt_next = cnt_next + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/ecc_123_rd_err_mon.sv
// Read-side ECC error monitor: one-deep output slot with poison tagging, saturating
// error counters, first-error capture and a level interrupt while an error is pending.
module ecc_123_rd_err_mon
   import ecc_err_pkg::*;
#(
   parameter int DATA_WIDTH = 123,
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_vld,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_sbit_err,
   input  logic                  in_dbit_err,
   input  logic                  in_ecc_fault,
   output logic                  out_vld,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_poison,
   output logic [CNT_WIDTH-1:0]  sbit_cnt,
   output logic [CNT_WIDTH-1:0]  dbit_cnt,
   output logic [CNT_WIDTH-1:0]  fault_cnt,
   output logic                  err_pend,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic [1:0]            err_type,
   input  logic                  err_clr,
   input  logic                  irq_en,
   output logic                  err_irq
);

   logic                  out_vld_reg;
   logic [DATA_WIDTH-1:0] out_data_reg;
   logic                  out_poison_reg;
   logic                  err_pend_reg, err_pend_next;
   logic [ADDR_WIDTH-1:0] err_addr_reg, err_addr_next;
   logic [1:0]            err_type_reg, err_type_next;
   logic                  err_irq_reg;

   logic                  accept;
   logic [2:0]            flag_vec;
   logic [CNT_WIDTH-1:0]  cnt_vec [3];

   assign in_ready = ~out_vld_reg | out_ready;
   assign accept   = in_vld & in_ready;
   assign flag_vec = {in_ecc_fault, in_dbit_err, in_sbit_err};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld_reg    <= 1'b0;
         out_data_reg   <= '0;
         out_poison_reg <= 1'b0;
      end else if (accept) begin
         out_vld_reg    <= 1'b1;
         out_data_reg   <= in_data;
         out_poison_reg <= in_dbit_err | in_ecc_fault;
      end else if (out_ready) begin
         out_vld_reg    <= 1'b0;
      end
   end

   // Counter index order matches flag_vec: 0 sbit, 1 dbit, 2 fault.
   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      ecc_sat_cnt #(
         .CNT_WIDTH(CNT_WIDTH)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (accept & flag_vec[gi]),
         .clr   (err_clr),
         .cnt   (cnt_vec[gi])
      );
   end

   // Clear is applied first so a same-cycle error beat re-arms the capture.
   always_comb begin
      err_pend_next = err_pend_reg;
      err_addr_next = err_addr_reg;
      err_type_next = err_type_reg;
      if (err_clr) begin
         err_pend_next = 1'b0;
         err_type_next = ERR_NONE;
      end
      if (accept && (|flag_vec) && !err_pend_next) begin
         err_pend_next = 1'b1;
         err_addr_next = in_addr;
         err_type_next = err_prio(in_sbit_err, in_dbit_err, in_ecc_fault);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_pend_reg <= 1'b0;
         err_addr_reg <= '0;
         err_type_reg <= ERR_NONE;
         err_irq_reg  <= 1'b0;
      end else begin
         err_pend_reg <= err_pend_next;
         err_addr_reg <= err_addr_next;
         err_type_reg <= err_type_next;
         err_irq_reg  <= err_pend_next & irq_en;
      end
   end

   assign out_vld    = out_vld_reg;
   assign out_data   = out_data_reg;
   assign out_poison = out_poison_reg;
   assign sbit_cnt   = cnt_vec[0];
   assign dbit_cnt   = cnt_vec[1];
   assign fault_cnt  = cnt_vec[2];
   assign err_pend   = err_pend_reg;
   assign err_addr   = err_addr_reg;
   assign err_type   = err_type_reg;
   assign err_irq    = err_irq_reg;

endmodule

// File: tb/tb_ecc_123_rd_err_mon.sv
// Bench for the ECC read error monitor: directed scenarios plus random traffic against a
// cycle-level reference model; a second instance with 4-bit counters exercises saturation.
module tb_ecc_123_rd_err_mon;

   localparam int DW = 123;
   localparam int AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, in_vld, in_sbit_err, in_dbit_err, in_ecc_fault;
   logic          out_ready, err_clr, irq_en;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;

   logic          in_ready, out_vld, out_poison, err_pend, err_irq;
   logic [DW-1:0] out_data;
   logic [15:0]   sbit_cnt, dbit_cnt, fault_cnt;
   logic [AW-1:0] err_addr;
   logic [1:0]    err_type;

   logic          s_in_ready, s_out_vld, s_out_poison, s_err_pend, s_err_irq;
   logic [DW-1:0] s_out_data;
   logic [3:0]    s_sbit_cnt, s_dbit_cnt, s_fault_cnt;
   logic [AW-1:0] s_err_addr;
   logic [1:0]    s_err_type;

   ecc_123_rd_err_mon #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_ready(in_ready), .in_addr(in_addr),
      .in_data(in_data), .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
      .in_ecc_fault(in_ecc_fault), .out_vld(out_vld), .out_ready(out_ready),
      .out_data(out_data), .out_poison(out_poison), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
      .fault_cnt(fault_cnt), .err_pend(err_pend), .err_addr(err_addr), .err_type(err_type),
      .err_clr(err_clr), .irq_en(irq_en), .err_irq(err_irq)
   );

   ecc_123_rd_err_mon #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_ready(s_in_ready), .in_addr(in_addr),
      .in_data(in_data), .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
      .in_ecc_fault(in_ecc_fault), .out_vld(s_out_vld), .out_ready(out_ready),
      .out_data(s_out_data), .out_poison(s_out_poison), .sbit_cnt(s_sbit_cnt),
      .dbit_cnt(s_dbit_cnt), .fault_cnt(s_fault_cnt), .err_pend(s_err_pend),
      .err_addr(s_err_addr), .err_type(s_err_type), .err_clr(err_clr), .irq_en(irq_en),
      .err_irq(s_err_irq)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit            m_vld, m_poison, m_pend, m_irq;
   logic [DW-1:0] m_data;
   int            m_cnt [3];
   int            m_cnt4 [3];
   logic [AW-1:0] m_addr;
   logic [1:0]    m_type;
   logic [DW-1:0] last_drv_data;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit vld, input logic [AW-1:0] addr,
                       input bit s, input bit d, input bit f,
                       input bit ord, input bit clr, input bit ien);
      bit            acc;
      bit            fl [3];
      logic [DW-1:0] data;
      data = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
      last_drv_data = data;
      rst_n = rst; in_vld = vld; in_addr = addr; in_data = data;
      in_sbit_err = s; in_dbit_err = d; in_ecc_fault = f;
      out_ready = ord; err_clr = clr; irq_en = ien;
      #1;
      if (rst) check("in_ready", 128'(in_ready), 128'(!m_vld || ord));
      acc = rst && vld && (!m_vld || ord);
      @(posedge clk);
      if (!rst) begin
         m_vld = 0; m_data = '0; m_poison = 0; m_pend = 0; m_addr = '0; m_type = 0; m_irq = 0;
         for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_cnt4[k] = 0; end
      end else begin
         if (acc) begin
            m_vld = 1; m_data = data; m_poison = d || f;
         end else if (m_vld && ord) begin
            m_vld = 0;
         end
         fl[0] = s; fl[1] = d; fl[2] = f;
         for (int k = 0; k < 3; k++) begin
            if (clr) begin m_cnt[k] = 0; m_cnt4[k] = 0; end
            if (acc && fl[k]) begin
               if (m_cnt[k] < 65535) m_cnt[k]++;
               if (m_cnt4[k] < 15) m_cnt4[k]++;
            end
         end
         if (clr) begin m_pend = 0; m_type = 0; end
         if (acc && (s || d || f) && !m_pend) begin
            m_pend = 1; m_addr = addr;
            m_type = f ? 2'd3 : (d ? 2'd2 : 2'd1);
         end
         m_irq = m_pend && ien;
      end
      #1;
      check("out_vld", 128'(out_vld), 128'(m_vld));
      check("out_data", 128'(out_data), 128'(m_data));
      check("out_poison", 128'(out_poison), 128'(m_poison));
      check("sbit_cnt", 128'(sbit_cnt), 128'(m_cnt[0]));
      check("dbit_cnt", 128'(dbit_cnt), 128'(m_cnt[1]));
      check("fault_cnt", 128'(fault_cnt), 128'(m_cnt[2]));
      check("err_pend", 128'(err_pend), 128'(m_pend));
      check("err_addr", 128'(err_addr), 128'(m_addr));
      check("err_type", 128'(err_type), 128'(m_type));
      check("err_irq", 128'(err_irq), 128'(m_irq));
      check("sat_sbit_cnt", 128'(s_sbit_cnt), 128'(m_cnt4[0]));
      check("sat_dbit_cnt", 128'(s_dbit_cnt), 128'(m_cnt4[1]));
      check("sat_fault_cnt", 128'(s_fault_cnt), 128'(m_cnt4[2]));
      $display("t=%0t rst_n=%0b vld=%0b acc=%0b addr=%02h sdf=%0b%0b%0b ord=%0b clr=%0b -> ovld=%0b poi=%0b cnt=%0d/%0d/%0d pend=%0b addr=%02h type=%0d irq=%0b",
               $time, rst, vld, acc, addr, s, d, f, ord, clr, out_vld, out_poison,
               sbit_cnt, dbit_cnt, fault_cnt, err_pend, err_addr, err_type, err_irq);
   endtask

   initial begin
      logic [DW-1:0] held;

      // 1: reset, then one clean beat
      step(0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
      step(0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
      check("t1_rst_out_vld", 128'(out_vld), 128'(0));
      check("t1_rst_err_type", 128'(err_type), 128'(0));
      step(1, 1, 8'h05, 0, 0, 0, 1, 0, 0);
      check("t1_out_vld", 128'(out_vld), 128'(1));
      check("t1_poison", 128'(out_poison), 128'(0));
      check("t1_pend", 128'(err_pend), 128'(0));

      // 2: sbit then dbit beat
      step(1, 1, 8'h10, 1, 0, 0, 1, 0, 0);
      step(1, 1, 8'h11, 0, 1, 0, 1, 0, 0);
      check("t2_sbit_cnt", 128'(sbit_cnt), 128'(1));
      check("t2_dbit_cnt", 128'(dbit_cnt), 128'(1));
      check("t2_err_addr", 128'(err_addr), 128'(8'h10));
      check("t2_err_type", 128'(err_type), 128'(1));
      check("t2_poison", 128'(out_poison), 128'(1));

      // 3: clear, then all-flag beat with irq enabled
      step(1, 0, 8'h00, 0, 0, 0, 1, 1, 1);
      step(1, 1, 8'h3F, 1, 1, 1, 1, 0, 1);
      check("t3_err_type", 128'(err_type), 128'(3));
      check("t3_err_addr", 128'(err_addr), 128'(8'h3F));
      check("t3_fault_cnt", 128'(fault_cnt), 128'(1));
      check("t3_err_irq", 128'(err_irq), 128'(1));

      // 4: backpressure with a full slot, then drain+accept in one cycle
      step(1, 0, 8'h00, 0, 0, 0, 1, 0, 1);
      step(1, 1, 8'h20, 0, 0, 0, 0, 0, 1);
      held = last_drv_data;
      step(1, 1, 8'h21, 0, 1, 0, 0, 0, 1);
      check("t4_dbit_hold", 128'(dbit_cnt), 128'(1));
      check("t4_data_stable", 128'(out_data), 128'(held));
      step(1, 1, 8'h21, 0, 1, 0, 1, 0, 1);
      check("t4_vld_no_bubble", 128'(out_vld), 128'(1));
      check("t4_dbit_inc", 128'(dbit_cnt), 128'(2));

      // 5: 20 sbit beats saturate the 4-bit counter
      step(1, 0, 8'h00, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 20; i++) step(1, 1, 8'(i), 1, 0, 0, 1, 0, 0);
      check("t5_sat_sbit", 128'(s_sbit_cnt), 128'(15));
      check("t5_wide_sbit", 128'(sbit_cnt), 128'(20));

      // 6: clear coincident with a fault beat, then reset mid-stream
      step(1, 1, 8'h22, 0, 0, 1, 1, 1, 1);
      check("t6_fault_cnt", 128'(fault_cnt), 128'(1));
      check("t6_sbit_cnt", 128'(sbit_cnt), 128'(0));
      check("t6_pend", 128'(err_pend), 128'(1));
      check("t6_err_addr", 128'(err_addr), 128'(8'h22));
      step(1, 1, 8'h23, 1, 0, 0, 0, 0, 1);
      step(0, 1, 8'h24, 1, 0, 0, 0, 0, 1);
      check("t6_rst_vld", 128'(out_vld), 128'(0));
      check("t6_rst_data", 128'(out_data), 128'(0));
      check("t6_rst_pend", 128'(err_pend), 128'(0));
      check("t6_rst_irq", 128'(err_irq), 128'(0));

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         step(1, ($urandom_range(9) < 7), 8'($urandom()),
              ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0),
              ($urandom_range(9) < 7), ($urandom_range(19) == 0), 1'($urandom()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
